// File: rtl/ex_alu.sv
// ex_alu: RV32I execute-stage ALU with a registered result behind a
// valid/ready handshake.
//   clk, rst_n             : clock, asynchronous active-low reset
//   flush                  : synchronous kill of in-flight / held result
//   in_valid / in_ready    : operation handshake (in_ready is combinational)
//   alu_ctrl, op_a, op_b   : {fun7_5, fun3} opcode and operands
//   out_valid / out_ready  : result handshake
//   result, zero           : registered result and result == 0
//   busy                   : iterative shift in progress
// Build option: define EX_ALU_BARREL_SHIFT_EN for a single-cycle barrel
// shifter; otherwise shifts run one bit per cycle.
module ex_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int unsigned SHAMT_W = 5;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  logic            r_out_valid, w_out_valid_n;
  logic [XLEN-1:0] r_result, w_result_n;
  logic            r_zero, w_zero_n;
  logic [XLEN-1:0] w_alu;
  logic            w_accept;

`ifdef EX_ALU_BARREL_SHIFT_EN

  // Single-cycle ALU including the full barrel shift.
  always_comb begin
    w_alu = '0;
    case (alu_ctrl)
      OP_ADD:  w_alu = op_a + op_b;
      OP_SUB:  w_alu = op_a - op_b;
      OP_SLL:  w_alu = op_a << op_b[SHAMT_W-1:0];
      OP_SLT:  w_alu = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: w_alu = XLEN'(op_a < op_b);
      OP_XOR:  w_alu = op_a ^ op_b;
      OP_SRL:  w_alu = op_a >> op_b[SHAMT_W-1:0];
      OP_SRA:  w_alu = XLEN'($signed(op_a) >>> op_b[SHAMT_W-1:0]);
      OP_OR:   w_alu = op_a | op_b;
      OP_AND:  w_alu = op_a & op_b;
      default: w_alu = '0;
    endcase
  end

  assign in_ready = (!r_out_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;
  assign busy     = 1'b0;

  // Output register next-state: load on accept, drop on consume or flush.
  always_comb begin
    w_out_valid_n = r_out_valid;
    w_result_n    = r_result;
    w_zero_n      = r_zero;
    if (r_out_valid && out_ready) w_out_valid_n = 1'b0;
    if (w_accept) begin
      w_result_n    = w_alu;
      w_zero_n      = (w_alu == '0);
      w_out_valid_n = 1'b1;
    end
    if (flush) w_out_valid_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
    end else begin
      r_out_valid <= w_out_valid_n;
      r_result    <= w_result_n;
      r_zero      <= w_zero_n;
    end
  end

`else

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]         r_state, w_state_n;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_n;
  logic [XLEN-1:0]    r_sh, w_sh_n, w_sh_step;
  logic [3:0]         r_kind, w_kind_n;
  logic               w_is_shift, w_long_shift;

  // One-bit shift step; the opcode selects direction and fill.
  function automatic logic [XLEN-1:0] f_shift1(input logic [3:0] kind,
                                               input logic [XLEN-1:0] v);
    case (kind)
      OP_SLL:  f_shift1 = {v[XLEN-2:0], 1'b0};
      OP_SRA:  f_shift1 = {v[XLEN-1], v[XLEN-1:1]};
      default: f_shift1 = {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

  // Single-cycle ALU; shifts here only cover shamt 0 and 1.
  always_comb begin
    w_alu = '0;
    case (alu_ctrl)
      OP_ADD:  w_alu = op_a + op_b;
      OP_SUB:  w_alu = op_a - op_b;
      OP_SLT:  w_alu = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: w_alu = XLEN'(op_a < op_b);
      OP_XOR:  w_alu = op_a ^ op_b;
      OP_OR:   w_alu = op_a | op_b;
      OP_AND:  w_alu = op_a & op_b;
      OP_SLL, OP_SRL, OP_SRA:
               w_alu = op_b[0] ? f_shift1(alu_ctrl, op_a) : op_a;
      default: w_alu = '0;
    endcase
  end

  assign w_is_shift   = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign w_long_shift = w_is_shift && (op_b[SHAMT_W-1:1] != '0);
  assign in_ready     = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !flush;
  assign w_accept     = in_valid && in_ready;
  assign busy         = (r_state == S_SHIFT);
  assign w_sh_step    = f_shift1(r_kind, r_sh);

  // Next-state logic: accept/compute in IDLE, one bit per cycle in SHIFT.
  always_comb begin
    w_state_n     = r_state;
    w_out_valid_n = r_out_valid;
    w_result_n    = r_result;
    w_zero_n      = r_zero;
    w_sh_n        = r_sh;
    w_cnt_n       = r_cnt;
    w_kind_n      = r_kind;
    if (r_out_valid && out_ready) w_out_valid_n = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_long_shift) begin
            // First bit is shifted on the accept edge, so N-1 remain.
            w_sh_n    = f_shift1(alu_ctrl, op_a);
            w_cnt_n   = op_b[SHAMT_W-1:0] - SHAMT_W'(1);
            w_kind_n  = alu_ctrl;
            w_state_n = S_SHIFT;
          end else begin
            w_result_n    = w_alu;
            w_zero_n      = (w_alu == '0);
            w_out_valid_n = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        w_sh_n  = w_sh_step;
        w_cnt_n = r_cnt - SHAMT_W'(1);
        if (r_cnt == SHAMT_W'(1)) begin
          w_result_n    = w_sh_step;
          w_zero_n      = (w_sh_step == '0);
          w_out_valid_n = 1'b1;
          w_state_n     = S_IDLE;
        end
      end
    endcase
    // Flush wins over accept and shift completion; result is kept.
    if (flush) begin
      w_out_valid_n = 1'b0;
      w_state_n     = S_IDLE;
      w_cnt_n       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_kind      <= '0;
    end else begin
      r_state     <= w_state_n;
      r_out_valid <= w_out_valid_n;
      r_result    <= w_result_n;
      r_zero      <= w_zero_n;
      r_sh        <= w_sh_n;
      r_cnt       <= w_cnt_n;
      r_kind      <= w_kind_n;
    end
  end

`endif

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;

endmodule

// File: doc/ex_alu.md
# ex_alu

Execute-stage ALU for the RV32I core, directly downstream of `alu_control`. It consumes the 4-bit `alu_t` operation code produced there, together with the two operands from the ID/EX path, and returns a registered result over a valid/ready handshake. Non-shift operations complete in one cycle. Shifts run on an iterative 1-bit-per-cycle shifter unless the barrel shifter is compiled in. A synchronous flush lets the hazard unit abandon an in-flight operation.

## Interface
- `XLEN`, default 32: datapath width. Only 32 is supported.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous kill of the in-flight and held result.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block can accept an operation this cycle.
- `alu_ctrl`  in  4  `alu_t` code, `{fun7_5, fun3}` encoding.
- `op_a`  in  XLEN  operand A (rs1 or PC).
- `op_b`  in  XLEN  operand B (rs2 or immediate). Shift amount is `op_b[4:0]`.
- `out_valid`  out  1  `result`/`zero` are valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  XLEN  registered ALU result.
- `zero`  out  1  registered `result == 0`, used by the branch unit.
- `busy`  out  1  FSM not in IDLE (iterative shift in progress).

## Operation
- Opcodes:
  - ADD=0000, SUB=1000: modulo 2^32.
  - SLL=0001.
  - SLT=0010: signed compare, result 1/0.
  - SLTU=0011: unsigned compare, result 1/0.
  - XOR=0100.
  - SRL=0101: zero fill.
  - SRA=1101: sign fill from `op_a[31]`.
  - OR=0110.
  - AND=0111.
  - Any other code: result 0.
- Handshake:
  - An operation is accepted on an edge where `in_valid && in_ready`.
  - `in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush`. This is combinational.
  - The output is held stable while `out_valid && !out_ready`.
  - A result is consumed on an edge where `out_valid && out_ready`.
- FSM states IDLE and SHIFT.
  - IDLE, accept of a non-shift op, or a shift with shamt 0 or 1: compute, load `result`/`zero`, set `out_valid`. Stay in IDLE.
  - IDLE, accept of a shift with shamt N≥2: load the shift register with `op_a` shifted once and the counter with N-1. Go to SHIFT.
  - SHIFT: shift one bit per cycle and decrement the counter. When the counter reaches 1, the final shift writes `result`, sets `out_valid`, and returns to IDLE.
- Back-to-back: if `out_ready` is high in the same cycle the output is consumed, a new op is accepted. Throughput is 1 op/cycle for non-shifts.
- Flush:
  - Clears `out_valid` and forces IDLE. The counter is discarded.
  - Has priority over accept and over shift completion.
  - `result` keeps its old value.
- Reset values: state IDLE, `out_valid`=0, `result`=0, `zero`=0, `busy`=0, counter 0. `in_ready` goes to 1 once `rst_n` is high.
- Reset mid-shift aborts immediately. No result is produced.

## Timing
- Non-shift, or shift with shamt ≤1: `out_valid` rises on the first edge after the accept edge's input sample, i.e. latency 1.
- Iterative shift, shamt N≥2: latency N cycles. `busy` is high for N-1 cycles and `in_ready` is low for those cycles.
- `zero` is always coherent with `result`, updated on the same edge.
- No combinational path from `op_a`/`op_b`/`alu_ctrl` to any output.
- The only combinational input-to-output paths are `out_ready` → `in_ready` and `flush` → `in_ready`.

## Configuration
- `EX_ALU_BARREL_SHIFT_EN` defined:
  - A single-cycle barrel shifter is used.
  - All ops have latency 1.
  - The SHIFT state and counter are not built, and `busy` is tied 0.
- Undefined:
  - The iterative shifter is used.
  - Shift latency is max(1, shamt) as above.

## Test plan
- ADD 0x7FFFFFFF+1, then SUB 5-5, with `out_ready`=1 throughout: results 0x80000000 with `zero`=0, then 0x00000000 with `zero`=1. Each at latency 1, on back-to-back cycles.
- SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0; illegal code 1001 → 0.
- SRA 0x80000000 by 31: without the macro, `busy` is high for 30 cycles and the result 0xFFFFFFFF arrives at cycle 31. With the macro, the same result arrives at cycle 1. SRL of the same operands gives 0x00000001.
- Backpressure: hold `out_ready`=0 for 5 cycles after an XOR result. `result` stays stable and `in_ready`=0. Releasing `out_ready` with `in_valid` high accepts the next op in the same cycle.
- Assert `flush` on the 3rd cycle of an SLL by 10: no `out_valid`, FSM in IDLE, and `in_ready`=1 on the following cycle.
- Drop `rst_n` mid-shift, asynchronously: `out_valid`, `busy` and `result` are immediately 0. After release, a fresh AND 0xF0F0 & 0xFF00 gives 0xF000.
